// File: rtl/regfile32x32_pkg.sv
// Shared register-file constants: architectural register numbers and sizes used by
// the register file, decode and syscall logic.
package regfile32x32_pkg;

  localparam int unsigned REG_COUNT = 32;
  localparam int unsigned DATA_W    = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_V0   = 5'd2;
  localparam logic [4:0] REG_A0   = 5'd4;

endpackage

// File: rtl/mux32x32.sv
// 32-input read-select mux; input i occupies bits [i*WIDTH +: WIDTH] of the flat bus.
module mux32x32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [32*WIDTH-1:0] ins,
  input  logic [4:0]          sel,
  output logic [WIDTH-1:0]    out
);

  always_comb begin
    out = '0;
    for (int i = 0; i < 32; i++) begin
      if (sel == 5'(i)) begin
        out = ins[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/regfile32x32.sv
// MIPS general register file: 31 stored registers plus hard-wired zero, one synchronous
// write port, two combinational read ports with optional write-through, $v0/$a0 taps.
module regfile32x32
  import regfile32x32_pkg::*;
#(
  parameter int unsigned WIDTH  = DATA_W,
  parameter bit          BYPASS = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [4:0]       wa,
  input  logic [WIDTH-1:0] wd,
  input  logic [4:0]       ra1,
  input  logic [4:0]       ra2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic [WIDTH-1:0] v0_out,
  output logic [WIDTH-1:0] a0_out
);

  logic [WIDTH-1:0]           regs_q [1:REG_COUNT-1];
  logic [REG_COUNT*WIDTH-1:0] regs_flat;
  logic [WIDTH-1:0]           mux_rd1;
  logic [WIDTH-1:0]           mux_rd2;
  logic                       wr_valid;
  logic                       byp1;
  logic                       byp2;

  // Case equality keeps an X on we from being treated as a write.
  assign wr_valid = (we === 1'b1) && (wa != REG_ZERO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < REG_COUNT; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_valid) begin
      for (int i = 1; i < REG_COUNT; i++) begin
        if (wa == 5'(i)) begin
          regs_q[i] <= wd;
        end
      end
    end
  end

  assign regs_flat[WIDTH-1:0] = '0;
  for (genvar g = 1; g < REG_COUNT; g++) begin : g_flat
    assign regs_flat[g*WIDTH +: WIDTH] = regs_q[g];
  end

  mux32x32 #(
    .WIDTH (WIDTH)
  ) u_mux_rd1 (
    .ins (regs_flat),
    .sel (ra1),
    .out (mux_rd1)
  );

  mux32x32 #(
    .WIDTH (WIDTH)
  ) u_mux_rd2 (
    .ins (regs_flat),
    .sel (ra2),
    .out (mux_rd2)
  );

  // wr_valid already excludes register 0, so a zero read address never bypasses.
  assign byp1 = BYPASS && !rst && wr_valid && (wa == ra1);
  assign byp2 = BYPASS && !rst && wr_valid && (wa == ra2);

  assign rd1    = byp1 ? wd : mux_rd1;
  assign rd2    = byp2 ? wd : mux_rd2;
  assign v0_out = regs_q[REG_V0];
  assign a0_out = regs_q[REG_A0];

endmodule

// File: tb/tb_regfile32x32.sv
// Self-checking bench: directed register-file scenarios plus random traffic compared
// every cycle against an array model, for both BYPASS=1 and BYPASS=0 instances.
module tb_regfile32x32;
  timeunit 1ns;
  timeprecision 10ps;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we  = 1'b0;
  logic [4:0]  wa  = '0;
  logic [31:0] wd  = '0;
  logic [4:0]  ra1 = '0;
  logic [4:0]  ra2 = '0;
  logic [31:0] rd1, rd2, v0_out, a0_out;
  logic [31:0] rd1_nb, rd2_nb, v0_nb, a0_nb;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [32];

  always #5 clk = ~clk;

  regfile32x32 #(.WIDTH(32), .BYPASS(1'b1)) dut (
    .clk (clk), .rst (rst), .we (we), .wa (wa), .wd (wd), .ra1 (ra1), .ra2 (ra2),
    .rd1 (rd1), .rd2 (rd2), .v0_out (v0_out), .a0_out (a0_out)
  );

  regfile32x32 #(.WIDTH(32), .BYPASS(1'b0)) dut_nb (
    .clk (clk), .rst (rst), .we (we), .wa (wa), .wd (wd), .ra1 (ra1), .ra2 (ra2),
    .rd1 (rd1_nb), .rd2 (rd2_nb), .v0_out (v0_nb), .a0_out (a0_nb)
  );

  // Architectural state: what software would see committed after each edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (we && wa != 5'd0) begin
      mem[wa] <= wd;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] ra, input bit byp);
    if (rst || ra == 5'd0) return 32'd0;
    if (byp && we && wa == ra) return wd;
    return mem[ra];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("cmp_rd1",    rd1,    exp_rd(ra1, 1'b1));
    check("cmp_rd2",    rd2,    exp_rd(ra2, 1'b1));
    check("cmp_rd1_nb", rd1_nb, exp_rd(ra1, 1'b0));
    check("cmp_rd2_nb", rd2_nb, exp_rd(ra2, 1'b0));
    check("cmp_v0",     v0_out, rst ? 32'd0 : mem[2]);
    check("cmp_a0",     a0_out, rst ? 32'd0 : mem[4]);
    check("cmp_v0_nb",  v0_nb,  rst ? 32'd0 : mem[2]);
    check("cmp_a0_nb",  a0_nb,  rst ? 32'd0 : mem[4]);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check("reset_rd1", rd1, 32'd0);
    check("reset_v0", v0_out, 32'd0);
    step();
    rst = 1'b0;
    step();

    // Load 1..31 on consecutive edges.
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; wa = 5'(i); wd = 32'hDEAD0000 + 32'(i);
      step();
    end
    we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(31 - i);
      #1;
      check("sweep_rd1", rd1, (i == 0) ? 32'd0 : 32'hDEAD0000 + 32'(i));
      check("sweep_rd2", rd2, (i == 31) ? 32'd0 : 32'hDEAD0000 + 32'(31 - i));
    end

    // Asynchronous clear, swept well inside one nanosecond.
    step();
    rst = 1'b1;
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(31 - i);
      #0.025;
      check("rstclr_rd1", rd1, 32'd0);
      check("rstclr_rd2", rd2, 32'd0);
    end
    check("rstclr_v0", v0_out, 32'd0);
    check("rstclr_a0", a0_out, 32'd0);
    step();
    rst = 1'b0;
    step();

    // Register 0 ignores writes and never bypasses.
    we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; ra1 = 5'd0;
    #1;
    check("r0_prewrite", rd1, 32'd0);
    step();
    we = 1'b0;
    #1;
    check("r0_after", rd1, 32'd0);

    // Bypass on both ports; BYPASS=0 instance shows the old value until the edge.
    we = 1'b1; wa = 5'd5; wd = 32'h11111111;
    step();
    wd = 32'h22222222; ra1 = 5'd5; ra2 = 5'd5;
    #1;
    check("byp_rd1", rd1, 32'h22222222);
    check("byp_rd2", rd2, 32'h22222222);
    check("byp_v0", v0_out, 32'd0);
    check("nobyp_rd1_pre", rd1_nb, 32'h11111111);
    check("nobyp_rd2_pre", rd2_nb, 32'h11111111);
    step();
    we = 1'b0;
    #1;
    check("nobyp_rd1_post", rd1_nb, 32'h22222222);

    // Syscall taps reflect committed state only.
    we = 1'b1; wa = 5'd2; wd = 32'h0000000A;
    #1;
    check("v0_during_write", v0_out, 32'd0);
    step();
    wa = 5'd4; wd = 32'h00000041;
    #1;
    check("a0_during_write", a0_out, 32'd0);
    step();
    we = 1'b0;
    #1;
    check("v0_tap", v0_out, 32'h0000000A);
    check("a0_tap", a0_out, 32'h00000041);

    // Reset and write in the same cycle: reset wins.
    we = 1'b1; wa = 5'd7; wd = 32'h12345678; rst = 1'b1;
    step();
    rst = 1'b0; we = 1'b0; ra1 = 5'd7;
    #1;
    check("collide_lost", rd1, 32'd0);
    step();
    we = 1'b1;
    step();
    we = 1'b0;
    #1;
    check("collide_next", rd1, 32'h12345678);

    // Random traffic, read addresses biased towards the write address.
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      we  = ($urandom_range(0, 3) != 0);
      wa  = 5'($urandom_range(0, 31));
      wd  = $urandom;
      ra1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      ra2 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      step();
    end
    rst = 1'b0; we = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile32x32.md
Name: regfile32x32

Overview:
- 32-entry × 32-bit MIPS general register file with one synchronous write port and two combinational read ports.
- Sits directly upstream of the read-select muxes: its 32 register outputs feed two mux32x32 instances, one per read port.
- Those mux outputs drive the ALU operand paths.
- Also exports $v0 and $a0 continuously for the syscall/halt logic.

Parameters:
- WIDTH, 32, data width of each register.
- BYPASS, 1, when 1, a same-cycle write to a read address is forwarded to that read port (write-through).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- we  input  1  write enable.
- wa  input  5  write register number.
- wd  input  WIDTH  write data.
- ra1  input  5  read port 1 register number.
- ra2  input  5  read port 2 register number.
- rd1  output  WIDTH  read port 1 data.
- rd2  output  WIDTH  read port 2 data.
- v0_out  output  WIDTH  current contents of register 2 ($v0).
- a0_out  output  WIDTH  current contents of register 4 ($a0).

Behaviour:
- Clock and reset (already decided): one clock, clk; reset rst is asynchronous and active-high.
- Storage: registers 1..31 are flops. Register 0 is not stored; the mux in0 input is tied to constant 0.
- Reset:
  - While rst=1, registers 1..31 are cleared to 0 immediately, without waiting for a clock edge.
  - Reset outputs: rd1=0, rd2=0, v0_out=0, a0_out=0.
  - Bypass is gated off while rst=1, so all outputs read 0 during reset.
- Write:
  - On a rising clk edge with rst=0, we=1 and wa!=0, register[wa] <= wd.
  - we=1 with wa=0 is silently discarded.
  - Write latency is 1 cycle: the new value is visible from the storage path after the edge.
- Read:
  - Purely combinational: rdN = register[raN] through mux32x32, 0-cycle latency.
  - raN=0 always returns 0, including when a bypass would otherwise apply.
- Bypass (BYPASS=1):
  - When rst=0, we=1, wa!=0 and wa==raN, rdN = wd combinationally, before the edge.
  - This lets WB and ID share a cycle.
  - Ports 1 and 2 bypass independently; both may match the same wa.
  - With BYPASS=0, rdN shows the old value until after the edge.
- v0_out and a0_out:
  - Read storage directly, never bypassed; they always reflect the committed state.
- Simultaneous events:
  - Reset asserted in the same cycle as a write: reset wins and the write is lost.
  - Reset deasserted asynchronously between edges: the first write takes effect at the next rising edge.
- Wrap/width: wa, ra1 and ra2 are full 5-bit values; no out-of-range addresses exist. No arithmetic is performed on data.
- Unknown inputs: X on we or wa must not corrupt registers other than the addressed one in simulation. Guard the write decode with a case equality on we.

Decomposition:
- Shared package / header constants:
  - REG_ZERO=5'd0, REG_V0=5'd2, REG_A0=5'd4.
  - REG_COUNT=32, DATA_W=32.
  - Reused by decode and syscall logic.
- Sub-module: reuse the existing mux32x32, two instances, one per read port. No new sub-module.
- Write decode and bypass compare stay inline.

Test Plan:
- Reset and clear: assert rst mid-simulation after registers 1..31 are loaded with 0xDEAD0000+i → within 1 ns and before any clk edge, every raN sweep 0..31 reads 0, and v0_out=a0_out=0.
- Write then read all: write 0xDEAD0000+i to regs 1..31 on consecutive edges, then sweep ra1/ra2 over 0..31 → rd = 0xDEAD0000+i for i≥1, and rd=0 for i=0.
- Register 0 immutable: we=1, wa=0, wd=0xFFFFFFFF, clock → ra1=0 reads 0. With ra1=0 during the write, rd1=0, i.e. no bypass.
- Bypass (BYPASS=1):
  - Setup: reg5=0x11111111. Drive we=1, wa=5, wd=0x22222222, ra1=ra2=5 before the edge.
  - Expected: rd1=rd2=0x22222222 pre-edge, v0_out unaffected.
  - BYPASS=0 variant: rd shows 0x11111111 until after the edge.
- Syscall taps: write reg2=0x0000000A and reg4=0x00000041 → v0_out=0x0000000A and a0_out=0x00000041 after the edge. During the write cycle, v0_out still holds its old value.
- Reset vs write collision: rst rises in the same cycle as we=1, wa=7, wd=0x12345678 → reg7 reads 0 after rst drops. A following write to reg7 at the next edge succeeds.
